z80_fetch_sequencer: RTL and testbench

Fetches Z80 instruction bytes from memory one at a time and accumulates them little-endian. It drives `instr_decoder` combinationally from its own registers until the decoder reports a complete instruction. The assembled instruction is then handed to the execute stage over a valid/ready handshake. Sits between the memory port and the execute sequencer, and owns the program counter.

---
 rtl/z80_fetch_sequencer_if.sv | 31 +++
 rtl/z80_fetch_sequencer.sv | 84 ++++++++
 tb/tb_z80_fetch_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/z80_fetch_sequencer_if.sv
// z80_fetch_sequencer_if: memory port, decoder link, instruction handoff and redirect bundle.
interface z80_fetch_sequencer_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [31:0] dec_instr;
    logic [1:0]  dec_op_len;
    logic [2:0]  dec_len;
    logic [7:0]  dec_group;
    logic [31:0] insn;
    logic [2:0]  insn_len;
    logic [7:0]  insn_group;
    logic [15:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_addr, mem_rd, dec_instr, dec_op_len,
        output insn, insn_len, insn_group, insn_pc, insn_valid,
        input  mem_data, mem_valid, dec_len, dec_group, insn_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_rd, dec_instr, dec_op_len,
        input  insn, insn_len, insn_group, insn_pc, insn_valid,
        output mem_data, mem_valid, dec_len, dec_group, insn_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/z80_fetch_sequencer.sv
// z80_fetch_sequencer: fetches Z80 instruction bytes, accumulates them little-endian
// until the decoder reports a full instruction, then offers it to execute.
module z80_fetch_sequencer #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter logic [7:0]  NEED_MORE_BYTES = 8'hFF
) (
    input logic                    clk,
    input logic                    reset_n,
    z80_fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {EVAL, REQ, OUT} state_t;

    state_t      state, state_nx;
    logic [15:0] pc;
    logic [31:0] ibuf;
    logic [2:0]  cnt;
    logic [1:0]  op_len;
    logic [31:0] insn_q;
    logic [2:0]  insn_len_q;
    logic [7:0]  insn_group_q;
    logic [15:0] insn_pc_q;
    logic        need_more;
    logic        short_buf;

    assign need_more      = bus.dec_group == NEED_MORE_BYTES;
    assign short_buf      = cnt < bus.dec_len;
    assign bus.mem_rd     = state == REQ;
    assign bus.mem_addr   = pc + {13'b0, cnt};
    assign bus.insn_valid = state == OUT;
    assign bus.insn       = insn_q;
    assign bus.insn_len   = insn_len_q;
    assign bus.insn_group = insn_group_q;
    assign bus.insn_pc    = insn_pc_q;
    assign bus.dec_instr  = ibuf;
    assign bus.dec_op_len = op_len;

    always_comb begin
        state_nx = bus.redirect    ? EVAL :
                   state == EVAL   ? ((need_more || short_buf) ? REQ : OUT) :
                   state == REQ    ? (bus.mem_valid ? EVAL : REQ) :
                   state == OUT    ? (bus.insn_ready ? EVAL : OUT) : EVAL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EVAL;
        else          state <= state_nx;
    end

    // Redirect wins over any in-flight read data or handshake in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc           <= RESET_PC;
            ibuf         <= '0;
            cnt          <= '0;
            op_len       <= '0;
            insn_q       <= '0;
            insn_len_q   <= '0;
            insn_group_q <= '0;
            insn_pc_q    <= '0;
        end else if (bus.redirect) begin
            pc     <= bus.redirect_pc;
            ibuf   <= '0;
            cnt    <= '0;
            op_len <= '0;
        end else if (state == EVAL) begin
            if (need_more) begin
                op_len <= bus.dec_len[1:0];
            end else if (!short_buf) begin
                insn_q       <= ibuf;
                insn_len_q   <= bus.dec_len;
                insn_group_q <= bus.dec_group;
                insn_pc_q    <= pc;
            end
        end else if (state == REQ && bus.mem_valid) begin
            ibuf[{cnt[1:0], 3'b000} +: 8] <= bus.mem_data;
            cnt                           <= cnt + 3'd1;
        end else if (state == OUT && bus.insn_ready) begin
            pc     <= pc + {13'b0, insn_len_q};
            ibuf   <= '0;
            cnt    <= '0;
            op_len <= '0;
        end
    end
endmodule

// File: tb/tb_z80_fetch_sequencer.sv
// tb_z80_fetch_sequencer: directed checks of the fetch sequencer against a small
// decoder model and byte memories, one DUT at RESET_PC 0 and one at 0xFFFF.
module tb_z80_fetch_sequencer;
    localparam logic [7:0] G_NOP        = 8'h00;
    localparam logic [7:0] G_LD_DD_NN   = 8'h01;
    localparam logic [7:0] G_LD_R_N     = 8'h02;
    localparam logic [7:0] G_LD_IXIY_NN = 8'h03;
    localparam logic [7:0] G_ILLEGAL    = 8'h7F;
    localparam logic [7:0] G_MORE       = 8'hFF;

    logic clk = 0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   wait_states = 0;
    int   cyc;
    logic [7:0] mem1 [0:65535];
    logic [7:0] mem2 [0:65535];
    logic [3:0] w1 = 0;
    logic [3:0] w2 = 0;
    logic       log_en = 0;
    logic [1:0] last_ol = 2'b11;
    logic [7:0] ol_n = 0;
    logic [5:0] ol_seq = 0;

    z80_fetch_sequencer_if f1();
    z80_fetch_sequencer_if f2();

    z80_fetch_sequencer #(.RESET_PC(16'h0000), .NEED_MORE_BYTES(G_MORE)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(f1)
    );
    z80_fetch_sequencer #(.RESET_PC(16'hFFFF), .NEED_MORE_BYTES(G_MORE)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(f2)
    );

    always #5 clk = ~clk;

    // Prefixed index ops take two NEED_MORE rounds so op_len walks 0,1,2.
    function automatic logic [10:0] decode(input logic [31:0] i, input logic [1:0] ol);
        logic [7:0] b0, b1;
        b0 = i[7:0];
        b1 = i[15:8];
        if (ol == 2'd0)
            return (b0 == 8'hDD || b0 == 8'hFD || b0 == 8'hED || b0 == 8'hCB) ? {3'd1, G_MORE} :
                   b0 == 8'h00 ? {3'd1, G_NOP} :
                   b0 == 8'h01 ? {3'd3, G_LD_DD_NN} :
                   b0 == 8'h3E ? {3'd2, G_LD_R_N} : {3'd1, G_ILLEGAL};
        if (ol == 2'd1)
            return (b0 == 8'hDD || b0 == 8'hFD) ? {3'd2, G_MORE} : {3'd2, G_ILLEGAL};
        return b1 == 8'h21 ? {3'd4, G_LD_IXIY_NN} : {3'd2, G_ILLEGAL};
    endfunction

    always_comb {f1.dec_len, f1.dec_group} = decode(f1.dec_instr, f1.dec_op_len);
    always_comb {f2.dec_len, f2.dec_group} = decode(f2.dec_instr, f2.dec_op_len);
    assign f1.mem_data  = mem1[f1.mem_addr];
    assign f2.mem_data  = mem2[f2.mem_addr];
    assign f1.mem_valid = f1.mem_rd && (32'(w1) >= wait_states);
    assign f2.mem_valid = f2.mem_rd && (32'(w2) >= wait_states);

    always @(posedge clk) begin
        w1 <= (f1.mem_rd && !f1.mem_valid) ? w1 + 4'd1 : 4'd0;
        w2 <= (f2.mem_rd && !f2.mem_valid) ? w2 + 4'd1 : 4'd0;
    end

    always @(negedge clk) begin
        if (!log_en) begin
            last_ol <= 2'b11;
            ol_n    <= 0;
            ol_seq  <= 0;
        end else if (f1.dec_op_len != last_ol) begin
            last_ol <= f1.dec_op_len;
            ol_n    <= ol_n + 8'd1;
            ol_seq  <= {ol_seq[3:0], f1.dec_op_len};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!f1.insn_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("valid_timeout", 32'(f1.insn_valid), 32'd1);
    endtask

    task automatic accept1();
        f1.insn_ready = 1;
        @(negedge clk);
        f1.insn_ready = 0;
    endtask

    task automatic check_insn(input string tag, input logic [31:0] i, input logic [2:0] l,
                              input logic [7:0] g, input logic [15:0] p);
        check({tag, "_insn"}, f1.insn, i);
        check({tag, "_len"}, 32'(f1.insn_len), 32'(l));
        check({tag, "_group"}, 32'(f1.insn_group), 32'(g));
        check({tag, "_pc"}, 32'(f1.insn_pc), 32'(p));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        for (int a = 0; a < 65536; a++) begin
            mem1[a] = 8'h00;
            mem2[a] = 8'h00;
        end
        {mem1[1], mem1[2], mem1[3], mem1[4]} = {8'hDD, 8'h21, 8'hCD, 8'hAB};
        {mem1[5], mem1[6]}                   = {8'hED, 8'h00};
        {mem1[7], mem1[8]}                   = {8'h3E, 8'h77};
        {mem1[9], mem1[10], mem1[11]}        = {8'h01, 8'hAA, 8'hBB};
        {mem1[16'h0100], mem1[16'h0101], mem1[16'h0102]} = {8'h01, 8'h34, 8'h12};
        {mem2[16'hFFFF], mem2[0]}            = {8'h3E, 8'h55};
        reset_n = 0;
        f1.insn_ready = 0; f1.redirect = 0; f1.redirect_pc = 0;
        f2.insn_ready = 0; f2.redirect = 0; f2.redirect_pc = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_rd", 32'(f1.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(f1.mem_addr), 32'h0000);
        check("rst_valid", 32'(f1.insn_valid), 32'd0);
        check_insn("rst", 32'h0, 3'd0, 8'h00, 16'h0000);
        check("rst2_mem_addr", 32'(f2.mem_addr), 32'hFFFF);
        reset_n = 1;
        wait_valid(cyc);
        check("nop_cycles", 32'(cyc), 32'd3);
        check_insn("nop", 32'h0, 3'd1, G_NOP, 16'h0000);
        accept1();
        check("nop_next_addr", 32'(f1.mem_addr), 32'h0001);
        log_en = 1;
        wait_valid(cyc);
        check_insn("ldix", 32'hABCD21DD, 3'd4, G_LD_IXIY_NN, 16'h0001);
        check("ldix_op_len_seq", {ol_n, 18'b0, ol_seq}, {8'd3, 18'b0, 6'b00_01_10});
        log_en = 0;
        accept1();
        check("ldix_next_addr", 32'(f1.mem_addr), 32'h0005);
        wait_valid(cyc);
        check_insn("ill", 32'h000000ED, 3'd2, G_ILLEGAL, 16'h0005);
        accept1();
        wait_valid(cyc);
        check_insn("bp", 32'h0000773E, 3'd2, G_LD_R_N, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {f1.insn_valid, f1.mem_rd, f1.insn[13:0], f1.insn_pc},
                  {1'b1, 1'b0, 14'h373E, 16'h0007});
        end
        accept1();
        check("bp_next_addr", 32'(f1.mem_addr), 32'h0009);
        k = 0;
        while (!(f1.mem_rd && f1.mem_addr == 16'h000A) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("redir_reach", 32'(f1.mem_valid), 32'd1);
        f1.redirect = 1;
        f1.redirect_pc = 16'h2000;
        @(negedge clk);
        f1.redirect = 0;
        check("redir_mem_rd", 32'(f1.mem_rd), 32'd0);
        check("redir_valid", 32'(f1.insn_valid), 32'd0);
        check("redir_addr", 32'(f1.mem_addr), 32'h2000);
        wait_valid(cyc);
        check_insn("redir_nop", 32'h0, 3'd1, G_NOP, 16'h2000);
        f1.insn_ready = 1;
        f1.redirect = 1;
        f1.redirect_pc = 16'h0100;
        @(negedge clk);
        f1.insn_ready = 0;
        f1.redirect = 0;
        check("racc_addr", 32'(f1.mem_addr), 32'h0100);
        check("racc_valid", 32'(f1.insn_valid), 32'd0);
        wait_states = 2;
        wait_valid(cyc);
        check_insn("ldbc", 32'h00123401, 3'd3, G_LD_DD_NN, 16'h0100);
        accept1();
        check("ldbc_next_addr", 32'(f1.mem_addr), 32'h0103);
        check("wrap_valid", 32'(f2.insn_valid), 32'd1);
        check("wrap_insn", f2.insn, 32'h0000553E);
        check("wrap_len", 32'(f2.insn_len), 32'd2);
        check("wrap_pc", 32'(f2.insn_pc), 32'hFFFF);
        f2.insn_ready = 1;
        @(negedge clk);
        f2.insn_ready = 0;
        check("wrap_next_addr", 32'(f2.mem_addr), 32'h0001);
        wait_states = 3;
        k = 0;
        while (!f1.mem_rd && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("midreq_reach", 32'(f1.mem_rd), 32'd1);
        reset_n = 0;
        #1;
        check("midreq_mem_rd", 32'(f1.mem_rd), 32'd0);
        check("midreq_addr", 32'(f1.mem_addr), 32'h0000);
        check("midreq_valid", 32'(f1.insn_valid), 32'd0);
        check_insn("midreq", 32'h0, 3'd0, 8'h00, 16'h0000);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
